memory_responder: RTL
=====================

Name: memory_responder

Overview:
- Memory-side responder for the CPU control unit's Read/Write strobes.
- Holds a word-addressed RAM. Accepts one access per request, inserts a configurable number of wait states, then returns read data with a Done handshake.
- Sits between MAR/MDR and the RAM array. MAR drives Addr, MDR drives WData and loads from RData when Done is high.
- Uses a four-phase handshake, so the control unit's FSM can stall in a memory state until Done is asserted.

Parameters:
- ADDR_W, 9, address width; the array holds 2^ADDR_W words.
- DATA_W, 32, word width.
- WAIT_CYCLES, 2, wait states inserted before the access is performed; legal range 0..15.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Read  in  1  read request; level, held until Done is observed.
- Write  in  1  write request; level, held until Done is observed.
- Addr  in  ADDR_W  word address from MAR.
- WData  in  DATA_W  write data from MDR.
- RData  out  DATA_W  read data to MDR.
- Done  out  1  access complete; held high until the request drops.
- Busy  out  1  high while an access is in progress (BUSY state).
- Err  out  1  protocol error flag for the current transaction.

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE.
  - RData = 0, Done = 0, Busy = 0, Err = 0, wait counter = 0.
  - Array contents are not cleared. A write in progress is abandoned with no array update.
- FSM states and transitions:
  - IDLE, on an edge where Read or Write is 1:
    - Latch Addr, WData and op (rd, wr, or err if both are 1).
    - Set cnt = WAIT_CYCLES.
    - Go to BUSY, with Busy = 1.
  - IDLE with no request: remain in IDLE; all outputs hold.
  - BUSY, on an edge where cnt != 0: cnt = cnt - 1.
  - BUSY, on an edge where cnt == 0:
    - rd: RData = mem[latched addr].
    - wr: mem[latched addr] = latched WData.
    - err: no array access, RData unchanged, Err = 1.
    - Then Done = 1, Busy = 0, go to DONE.
  - DONE, on an edge where Read = 0 and Write = 0: Done = 0, Err = 0, go to IDLE.
  - DONE with a request still asserted: remain in DONE, Done = 1. No second access is performed.
- Latency: the request is sampled at edge E0; Done rises after edge E0 + WAIT_CYCLES + 1. With WAIT_CYCLES = 0, Done rises one edge after sampling.
- Minimum turnaround: a new request is accepted no earlier than the edge after DONE returns to IDLE, so back-to-back accesses cost WAIT_CYCLES + 3 edges.
- Inputs while BUSY or DONE:
  - Addr, WData, Read and Write changes are ignored; only the latched values are used.
  - If the request drops during BUSY, the access still completes and Done pulses for one cycle (DONE sees no request on the next edge).
- RData: changes only on a completed read; it holds its value through writes, errors and idle.
- Address: all 2^ADDR_W addresses are valid, and there is no wrap or alias.
- Read-after-write to the same address returns the newly written data.
- Reads of never-written locations return undefined data; benches must initialise first.
- Combinational RAM read on latched address is permitted; output RData remains registered.

Test Plan:
- WAIT_CYCLES = 2, Write = 1, Addr = 0x005, WData = 0xDEADBEEF, sampled at E0:
  - Busy = 1 after E0, E1 and E2.
  - Done = 1 after E3.
  - Drop Write → Done = 0 after the next edge.
  - Then Read at 0x005 → RData = 0xDEADBEEF, with Done after 3 edges.
- Read held high for 6 cycles after Done:
  - Done stays 1 and RData is stable.
  - Only one access is performed: a write to the same address from a second agent is not visible until a new request.
- Read = 1 and Write = 1 together at Addr = 0x010 holding 0x12345678:
  - Err = 1 and Done = 1 after 3 edges.
  - mem[0x010] and RData are unchanged.
  - Err clears with Done.
- Write 0xA5A5A5A5 to 0x1FF, then Reset asserted mid-BUSY (after E1):
  - Outputs are immediately 0 and the state is IDLE.
  - A subsequent read of 0x1FF returns its previous value.
  - A normal write to 0x1FF, then a read, returns the written value.
- WAIT_CYCLES = 0 instance:
  - Read sampled at E0 → Done after E1.
  - Four back-to-back writes/reads to 0x000..0x003 complete in 3 edges each, and data round-trips.
- Request dropped during BUSY (Read deasserted after E1, WAIT_CYCLES = 2):
  - Done is high for exactly one cycle after E3.
  - RData is updated.
  - IDLE is reached after E4.

Source files
------------

// File: rtl/memory_responder_if.sv
// Handshake bus between the CPU control unit (MAR/MDR side) and the memory responder.
interface memory_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic [DATA_W-1:0] RData;
  logic              Done;
  logic              Busy;
  logic              Err;

  modport master (
    output Read, Write, Addr, WData,
    input  RData, Done, Busy, Err
  );

  modport slave (
    input  Read, Write, Addr, WData,
    output RData, Done, Busy, Err
  );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM behind a four-phase Read/Write/Done handshake with
// a fixed number of wait states between accepting a request and performing it.
//
// state | meaning
// IDLE  | waiting for Read or Write; outputs hold
// BUSY  | request latched, counting down wait states, access on terminal count
// DONE  | Done high until both Read and Write drop
module memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic                Clock,
  input logic                Reset,
  memory_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} op_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  state_t            state_next;
  op_t               op;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata;
  logic              req;
  logic              accept;
  logic              finish;

  // Array is deliberately outside the reset domain so contents survive Reset.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign req = bus.Read | bus.Write;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus accept/finish strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait-state down-counter and registered read data.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op        <= OP_RD;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        lat_addr  <= bus.Addr;
        lat_wdata <= bus.WData;
        cnt       <= CNT_INIT;
        if (bus.Read && bus.Write) op <= OP_ERR;
        else if (bus.Read)         op <= OP_RD;
        else                       op <= OP_WR;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish && op == OP_RD) rdata <= mem[lat_addr];
    end
  end

  // Array write on terminal count; a reset during BUSY never reaches here.
  always_ff @(posedge Clock) begin
    if (finish && op == OP_WR) mem[lat_addr] <= lat_wdata;
  end

  assign bus.RData = rdata;
  assign bus.Busy  = (state == BUSY);
  assign bus.Done  = (state == DONE);
  assign bus.Err   = (state == DONE) && (op == OP_ERR);

endmodule
